// File: rtl/note_lane_scheduler.sv
// Note lane scheduler: owns the table of falling notes for the 4-lane play field.
// Spawns notes, advances them once per video frame, retires missed notes,
// arbitrates player strikes and produces a registered per-pixel note overlay flag.
module note_lane_scheduler #(
    parameter int NUM_SLOTS    = 8,
    parameter int LANE_X0      = 120,
    parameter int LANE_WIDTH   = 100,
    parameter int NOTE_H       = 20,
    parameter int SPEED        = 2,
    parameter int HIT_Y        = 400,
    parameter int HIT_WIN      = 16,
    parameter int VIDEO_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       screen_end,
    input  logic       spawn_valid,
    input  logic [1:0] spawn_lane,
    output logic       spawn_ready,
    input  logic       hit_valid,
    input  logic [1:0] hit_lane,
    output logic       hit_ready,
    output logic       hit_done,
    output logic       hit_good,
    output logic       miss_pulse,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       note_pixel,
    output logic [1:0] note_lane,
    output logic [3:0] live_count
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic signed [10:0] WIN_S = 11'(HIT_WIN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADVANCE  = 2'd1,
        HIT_SCAN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [1:0]             hit_lane_q;
    logic [NUM_SLOTS-1:0]   valid_q;
    logic [1:0]             lane_q [NUM_SLOTS];
    logic [9:0]             ytop_q [NUM_SLOTS];
    logic                   screen_end_q;
    logic                   tick_pending_q;
    logic                   tick_pending_d;
    logic                   run_q;
    logic                   hit_done_q;
    logic                   hit_good_q;
    logic                   miss_pulse_q;
    logic                   note_pixel_q;
    logic                   note_pixel_d;
    logic [1:0]             note_lane_q;
    logic [1:0]             note_lane_d;
    logic [3:0]             live_count_q;
    logic [3:0]             live_count_d;

    logic                   tick;
    logic                   enter_adv;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic                   cur_valid;
    logic [1:0]             cur_lane;
    logic [9:0]             cur_ytop;
    logic [9:0]             adv_sum;
    logic                   retire;
    logic signed [10:0]     hit_diff;
    logic                   in_win;
    logic                   last_slot;
    logic [NUM_SLOTS-1:0]   slot_hit;

    // Left pixel edge of a lane, widened so the right edge never wraps.
    function automatic logic [10:0] laneLeft(input logic [1:0] l);
        return 11'(LANE_X0) + 11'(l) * 11'(LANE_WIDTH);
    endfunction

    // A frame tick is the rising edge of the multi-cycle screen_end level; a tick
    // arriving in the same cycle ADVANCE is entered must survive for the next frame.
    assign tick           = screen_end && !screen_end_q;
    assign enter_adv      = (state_q == IDLE) && tick_pending_q;
    assign tick_pending_d = tick || (tick_pending_q && !enter_adv);

    // Handshakes: frame service beats strikes, strikes beat spawns. run_q keeps
    // both readies low while reset is held and for the first cycle after it.
    assign hit_ready   = run_q && (state_q == IDLE) && !tick_pending_q;
    assign spawn_ready = hit_ready && !hit_valid && free_found;

    assign hit_done   = hit_done_q;
    assign hit_good   = hit_good_q;
    assign miss_pulse = miss_pulse_q;
    assign note_pixel = note_pixel_q;
    assign note_lane  = note_lane_q;
    assign live_count = live_count_q;

    // Lowest-index free slot, found by scanning downward so the smallest index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Per-slot arithmetic for whichever slot the sequential scan is visiting.
    always_comb begin
        cur_valid = valid_q[idx_q];
        cur_lane  = lane_q[idx_q];
        cur_ytop  = ytop_q[idx_q];
        adv_sum   = cur_ytop + 10'(SPEED);
        retire    = adv_sum >= 10'(VIDEO_HEIGHT);
        hit_diff  = signed'({1'b0, cur_ytop}) + signed'(11'(NOTE_H / 2)) - signed'(11'(HIT_Y));
        in_win    = (hit_diff <= WIN_S) && (hit_diff >= -WIN_S);
        last_slot = (idx_q == LAST_IDX);
    end

    // Pixel overlap test against every slot; the lowest overlapping slot supplies the lane.
    always_comb begin
        note_pixel_d = 1'b0;
        note_lane_d  = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_hit[i] = valid_q[i]
                       && ({1'b0, x} >= laneLeft(lane_q[i]))
                       && ({1'b0, x} <  laneLeft(lane_q[i]) + 11'(LANE_WIDTH))
                       && ({1'b0, y} >= ytop_q[i])
                       && ({2'b00, y} < {1'b0, ytop_q[i]} + 11'(NOTE_H));
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                note_pixel_d = 1'b1;
                note_lane_d  = lane_q[i];
            end
        end
    end

    // Population count of the slot table, registered to form live_count.
    always_comb begin
        live_count_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            live_count_d = live_count_d + 4'(valid_q[i]);
        end
    end

    // Pixel overlay and live count registers, independent of the scheduler FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_pixel_q <= 1'b0;
            note_lane_q  <= 2'd0;
            live_count_q <= 4'd0;
        end else begin
            note_pixel_q <= note_pixel_d;
            note_lane_q  <= note_lane_d;
            live_count_q <= live_count_d;
        end
    end

    // Scheduler FSM: owns the slot table, frame tick tracking and the strike/miss pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            hit_lane_q     <= 2'd0;
            valid_q        <= '0;
            screen_end_q   <= 1'b0;
            tick_pending_q <= 1'b0;
            run_q          <= 1'b0;
            hit_done_q     <= 1'b0;
            hit_good_q     <= 1'b0;
            miss_pulse_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane_q[i] <= 2'd0;
                ytop_q[i] <= 10'd0;
            end
        end else begin
            run_q          <= 1'b1;
            screen_end_q   <= screen_end;
            tick_pending_q <= tick_pending_d;
            hit_done_q     <= 1'b0;
            hit_good_q     <= 1'b0;
            miss_pulse_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_pending_q) begin
                        state_q <= ADVANCE;
                        idx_q   <= '0;
                    end else if (hit_valid && hit_ready) begin
                        hit_lane_q <= hit_lane;
                        state_q    <= HIT_SCAN;
                        idx_q      <= '0;
                    end else if (spawn_valid && spawn_ready) begin
                        valid_q[free_idx] <= 1'b1;
                        lane_q[free_idx]  <= spawn_lane;
                        ytop_q[free_idx]  <= 10'd0;
                    end
                end
                ADVANCE: begin
                    if (cur_valid) begin
                        if (retire) begin
                            valid_q[idx_q] <= 1'b0;
                            miss_pulse_q   <= 1'b1;
                        end else begin
                            ytop_q[idx_q] <= adv_sum;
                        end
                    end
                    idx_q <= idx_q + 1'b1;
                    if (last_slot) begin
                        state_q <= IDLE;
                    end
                end
                HIT_SCAN: begin
                    if (cur_valid && (cur_lane == hit_lane_q) && in_win) begin
                        valid_q[idx_q] <= 1'b0;
                        hit_done_q     <= 1'b1;
                        hit_good_q     <= 1'b1;
                        state_q        <= IDLE;
                    end else if (last_slot) begin
                        hit_done_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Self-checking bench for note_lane_scheduler: a behavioural slot-table model,
// a pixel-vector table, and a scoreboard queue of expected strike results.
module tb_note_lane_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       screenEnd;
    logic       spawnValid;
    logic [1:0] spawnLane;
    logic       spawnReady;
    logic       hitValid;
    logic [1:0] hitLane;
    logic       hitReady;
    logic       hitDone;
    logic       hitGood;
    logic       missPulse;
    logic [9:0] px;
    logic [8:0] py;
    logic       notePixel;
    logic [1:0] noteLane;
    logic [3:0] liveCount;

    // 100 MHz clock.
    always #5 clk = ~clk;

    note_lane_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .screen_end (screenEnd),
        .spawn_valid(spawnValid),
        .spawn_lane (spawnLane),
        .spawn_ready(spawnReady),
        .hit_valid  (hitValid),
        .hit_lane   (hitLane),
        .hit_ready  (hitReady),
        .hit_done   (hitDone),
        .hit_good   (hitGood),
        .miss_pulse (missPulse),
        .x          (px),
        .y          (py),
        .note_pixel (notePixel),
        .note_lane  (noteLane),
        .live_count (liveCount)
    );

    int checks = 0;
    int passes = 0;
    int missSeen = 0;
    bit expGood;
    bit hitExpQ[$];

    typedef struct {
        bit pix;
        int lane;
    } pixExp_t;
    pixExp_t pixQ[$];

    typedef struct {
        int x;
        int y;
        bit expPixel;
        int expLane;
    } pixVec_t;
    pixVec_t pixTable[8];

    bit mValid[8];
    int mLane[8];
    int mYtop[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strike results and miss pulses are collected as the DUT produces them.
    always @(negedge clk) begin
        if (missPulse) missSeen++;
        if (hitDone) begin
            if (hitExpQ.size() == 0) begin
                checkOutput("unexpected hit_done", 1, 0);
            end else begin
                expGood = hitExpQ.pop_front();
                checkOutput("hit_good", hitGood, expGood);
            end
        end
    end

    function automatic int modelLive();
        int n = 0;
        for (int i = 0; i < 8; i++) if (mValid[i]) n++;
        return n;
    endfunction

    function automatic bit modelFree();
        return modelLive() < 8;
    endfunction

    task automatic modelTick(inout int missExp);
        for (int i = 0; i < 8; i++) begin
            if (mValid[i]) begin
                if (mYtop[i] + 2 >= 480) begin
                    mValid[i] = 1'b0;
                    missExp++;
                end else begin
                    mYtop[i] = mYtop[i] + 2;
                end
            end
        end
    endtask

    function automatic bit modelHit(input int lane);
        for (int i = 0; i < 8; i++) begin
            if (mValid[i] && mLane[i] == lane) begin
                int d = mYtop[i] + 10 - 400;
                if (d >= -16 && d <= 16) begin
                    mValid[i] = 1'b0;
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic modelPixel(input int qx, input int qy, output bit pix, output int lane);
        pix = 1'b0;
        lane = 0;
        for (int i = 7; i >= 0; i--) begin
            if (mValid[i] && qx >= 120 + mLane[i] * 100 && qx < 220 + mLane[i] * 100
                && qy >= mYtop[i] && qy < mYtop[i] + 20) begin
                pix = 1'b1;
                lane = mLane[i];
            end
        end
    endtask

    // Drive one pixel coordinate, queue its expectation, compare one clock later.
    task automatic applyStimulus(input string name, input int qx, input int qy,
                                 input bit expPix, input int expLane);
        pixExp_t e;
        px = 10'(qx);
        py = 9'(qy);
        e.pix = expPix;
        e.lane = expLane;
        pixQ.push_back(e);
        step();
        e = pixQ.pop_front();
        checkOutput({name, " note_pixel"}, notePixel, e.pix);
        checkOutput({name, " note_lane"}, noteLane, e.lane);
    endtask

    task automatic checkPixel(input string name, input int qx, input int qy);
        bit p;
        int l;
        modelPixel(qx, qy, p, l);
        applyStimulus(name, qx, qy, p, l);
    endtask

    task automatic doReset();
        reset = 1'b1;
        screenEnd = 1'b0;
        spawnValid = 1'b0;
        spawnLane = 2'd0;
        hitValid = 1'b0;
        hitLane = 2'd0;
        px = 10'd0;
        py = 9'd0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mValid[i] = 1'b0;
            mLane[i] = 0;
            mYtop[i] = 0;
        end
        step();
        step();
        missSeen = 0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (!hitReady && n < 40) begin
            step();
            n++;
        end
        if (!hitReady) checkOutput({name, " idle timeout"}, 0, 1);
    endtask

    task automatic applySpawn(input int lane);
        bit expReady = modelFree();
        spawnValid = 1'b1;
        spawnLane = 2'(lane);
        #1;
        checkOutput("spawn_ready", spawnReady, expReady);
        step();
        spawnValid = 1'b0;
        if (expReady) begin
            for (int i = 0; i < 8; i++) begin
                if (!mValid[i]) begin
                    mValid[i] = 1'b1;
                    mLane[i] = lane;
                    mYtop[i] = 0;
                    break;
                end
            end
        end
    endtask

    task automatic applyTick(inout int missExp);
        screenEnd = 1'b1;
        step();
        step();
        step();
        screenEnd = 1'b0;
        waitIdle("tick");
        modelTick(missExp);
    endtask

    task automatic applyHit(input int lane);
        int n = 0;
        waitIdle("hit");
        hitValid = 1'b1;
        hitLane = 2'(lane);
        #1;
        checkOutput("hit_ready", hitReady, 1);
        step();
        hitValid = 1'b0;
        hitExpQ.push_back(modelHit(lane));
        while (hitExpQ.size() != 0 && n < 20) begin
            step();
            n++;
        end
        checkOutput("hit latency within 9", (hitExpQ.size() == 0 && n <= 9) ? 1 : 0, 1);
        hitExpQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int missExp;
        int n;
        pixTable[0] = '{320,  5, 1'b1, 2};
        pixTable[1] = '{319,  5, 1'b0, 0};
        pixTable[2] = '{419, 19, 1'b1, 2};
        pixTable[3] = '{420,  5, 1'b0, 0};
        pixTable[4] = '{350, 20, 1'b0, 0};
        pixTable[5] = '{350,  0, 1'b1, 2};
        pixTable[6] = '{220,  5, 1'b0, 0};
        pixTable[7] = '{500, 10, 1'b0, 0};

        // 1: reset state, single spawn, pixel table
        doReset();
        checkOutput("reset live_count", liveCount, 0);
        checkOutput("reset note_pixel", notePixel, 0);
        checkOutput("reset hit_done", hitDone, 0);
        checkOutput("reset miss_pulse", missPulse, 0);
        applySpawn(2);
        step();
        checkOutput("live_count one", liveCount, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("pixvec%0d", i), pixTable[i].x, pixTable[i].y,
                          pixTable[i].expPixel, pixTable[i].expLane);
        end

        // 2: fill the table, ninth spawn refused, full scan on a miss-window strike
        doReset();
        for (int i = 0; i < 9; i++) applySpawn(i % 4);
        step();
        checkOutput("live_count full", liveCount, 8);
        applyHit(1);
        step();
        checkOutput("live_count after empty strike", liveCount, 8);

        // 3: one note falls off the bottom after 240 frames
        doReset();
        missExp = 0;
        applySpawn(1);
        for (int i = 0; i < 239; i++) applyTick(missExp);
        checkOutput("no miss before 240", missSeen, 0);
        checkPixel("ytop 478", 250, 478);
        checkPixel("above 478", 250, 477);
        applyTick(missExp);
        checkOutput("miss count", missSeen, missExp);
        checkOutput("miss exactly one", missExp, 1);
        step();
        checkOutput("live_count after miss", liveCount, 0);

        // 4: strike window boundaries with two notes in lane 3
        doReset();
        missExp = 0;
        applySpawn(3);
        applyTick(missExp);
        applyTick(missExp);
        applySpawn(3);
        for (int i = 0; i < 148; i++) applyTick(missExp);
        applyHit(3);
        checkPixel("note kept at 300", 450, 300);
        for (int i = 0; i < 37; i++) applyTick(missExp);
        applyHit(0);
        applyHit(3);
        step();
        checkOutput("live_count after good hit", liveCount, 1);
        applyHit(3);
        for (int i = 0; i < 18; i++) applyTick(missExp);
        checkPixel("note at 406", 450, 406);
        applyHit(3);
        step();
        checkOutput("live_count empty", liveCount, 0);

        // 5: frame edge arriving mid strike is serviced right after hit_done
        doReset();
        missExp = 0;
        applySpawn(0);
        hitValid = 1'b1;
        hitLane = 2'd0;
        step();
        hitValid = 1'b0;
        hitExpQ.push_back(modelHit(0));
        screenEnd = 1'b1;
        step();
        step();
        step();
        screenEnd = 1'b0;
        n = 0;
        while (!hitDone && n < 15) begin
            step();
            n++;
        end
        checkOutput("hit_done seen", hitDone, 1);
        checkOutput("hit_ready low at hit_done", hitReady, 0);
        step();
        waitIdle("post-hit advance");
        modelTick(missExp);
        checkOutput("hit queue drained", hitExpQ.size(), 0);
        checkPixel("advanced top", 150, 2);
        checkPixel("advanced above", 150, 1);
        checkPixel("advanced bottom", 150, 21);
        for (int i = 0; i < 20; i++) step();
        checkPixel("single advance", 150, 22);

        // 6: reset asserted in the middle of ADVANCE
        doReset();
        applySpawn(0);
        applySpawn(1);
        applySpawn(2);
        px = 10'd150;
        py = 9'd5;
        screenEnd = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("rst note_pixel", notePixel, 0);
        checkOutput("rst note_lane", noteLane, 0);
        checkOutput("rst live_count", liveCount, 0);
        checkOutput("rst hit_done", hitDone, 0);
        checkOutput("rst hit_good", hitGood, 0);
        checkOutput("rst miss_pulse", missPulse, 0);
        checkOutput("rst spawn_ready", spawnReady, 0);
        checkOutput("rst hit_ready", hitReady, 0);
        step();
        screenEnd = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
        for (int i = 0; i < 12; i++) step();
        checkOutput("no miss after reset", missSeen, 0);
        checkOutput("live_count after reset", liveCount, 0);
        checkPixel("pixel cleared", 150, 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
